// File: rtl/p2p_cfg_regs_if.sv
// -----------------------------------------------------------------------------
// p2p_cfg_regs_if
// AXI-lite register-access bundle for p2p_cfg_regs.
//   Write address : awvalid, awready, awaddr[ADDR_WIDTH]
//   Write data    : wvalid, wready, wdata[32] (no strobes, all bytes written)
//   Write resp    : bvalid, bready (response is always OKAY, no resp field)
//   Read address  : arvalid, arready, araddr[ADDR_WIDTH]
//   Read data     : rvalid, rready, rdata[32]
// Modports: master (bus initiator), slave (register block).
// -----------------------------------------------------------------------------
interface p2p_cfg_regs_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic                  bvalid;
    logic                  bready;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/p2p_cfg_regs.sv
// -----------------------------------------------------------------------------
// p2p_cfg_regs
// AXI-lite configuration/statistics block for a packet filter.
//   axil_aclk  : sole clock, rising edge
//   axil_rst   : synchronous active-high reset
//   s_axil     : AXI-lite slave port (p2p_cfg_regs_if.slave)
//   pkt_valid  : one packet classified this cycle
//   pkt_drop   : packet dropped (qualified by pkt_valid)
//   rule_hit   : per-rule match (qualified by pkt_valid)
//   rule_cfg   : active rules, rule r at [r*192+:192] = {ipv4, ipv6[127:0], port}
//   rule_en    : active per-rule enable
// Word map: rule r at words r*8+0..7 (ipv4, ipv6 hi..lo, port, ctrl, hit count),
// 0x100 total, 0x101 dropped, 0x102 commit, 0x103 clear (bit0 clears counters).
// Optional build macro P2P_CFG_SHADOW_COMMIT_EN: rule/ctrl writes land in a
// shadow copy, reads see the shadow, and a commit write copies it atomically.
// -----------------------------------------------------------------------------
module p2p_cfg_regs #(
    parameter int NUM_RULES  = 2,
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                     axil_aclk,
    input  logic                     axil_rst,
    p2p_cfg_regs_if.slave            s_axil,
    input  logic                     pkt_valid,
    input  logic                     pkt_drop,
    input  logic [NUM_RULES-1:0]     rule_hit,
    output logic [NUM_RULES*192-1:0] rule_cfg,
    output logic [NUM_RULES-1:0]     rule_en
);
    localparam logic [31:0]          BAD_RD   = 32'hDEAD_BEEF;
    localparam logic [31:0]          W_TOTAL  = 32'h0000_0100;
    localparam logic [31:0]          W_DROP   = 32'h0000_0101;
    localparam logic [31:0]          W_COMMIT = 32'h0000_0102;
    localparam logic [31:0]          W_CLEAR  = 32'h0000_0103;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Slot 5 holds ipv4 and slot 0 holds port, so the packed rule word reads
    // {ipv4, ipv6[127:96] .. ipv6[31:0], port} from MSB down; field f -> slot 5-f.
    typedef logic [5:0][31:0] rule_words_t;

    rule_words_t [NUM_RULES-1:0]          cfg_q, cfg_d;
    logic [NUM_RULES-1:0]                 en_q, en_d;
`ifdef P2P_CFG_SHADOW_COMMIT_EN
    rule_words_t [NUM_RULES-1:0]          sh_cfg_q, sh_cfg_d;
    logic [NUM_RULES-1:0]                 sh_en_q, sh_en_d;
`endif
    logic [NUM_RULES-1:0][CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]                 total_cnt_q, total_cnt_d;
    logic [CNT_WIDTH-1:0]                 drop_cnt_q, drop_cnt_d;
    logic                                 bvalid_q, bvalid_d;
    logic                                 rvalid_q, rvalid_d;
    logic [31:0]                          rdata_q, rdata_d;

    logic        wr_fire_s;
    logic        rd_fire_s;
    logic [31:0] aw_word_s;
    logic [31:0] ar_word_s;
    logic [31:0] rd_val_s;
    logic        unused_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Byte-lane bits are ignored by design.
    assign unused_s = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // Handshakes are combinational so ready coincides with the accepting cycle.
    assign s_axil.awready = wr_fire_s;
    assign s_axil.wready  = wr_fire_s;
    assign s_axil.arready = rd_fire_s;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign rule_cfg       = cfg_q;
    assign rule_en        = en_q;

    // Next-state for registers, counters and the two response channels.
    always_comb begin
        wr_fire_s   = s_axil.awvalid & s_axil.wvalid & ~bvalid_q & ~axil_rst;
        rd_fire_s   = s_axil.arvalid & ~rvalid_q & ~axil_rst;
        aw_word_s   = 32'(s_axil.awaddr[ADDR_WIDTH-1:2]);
        ar_word_s   = 32'(s_axil.araddr[ADDR_WIDTH-1:2]);
        cfg_d       = cfg_q;
        en_d        = en_q;
`ifdef P2P_CFG_SHADOW_COMMIT_EN
        sh_cfg_d    = sh_cfg_q;
        sh_en_d     = sh_en_q;
`endif
        total_cnt_d = pkt_valid ? sat_inc(total_cnt_q) : total_cnt_q;
        drop_cnt_d  = (pkt_valid && pkt_drop) ? sat_inc(drop_cnt_q) : drop_cnt_q;
        for (int r = 0; r < NUM_RULES; r++) begin
            hit_cnt_d[r] = (pkt_valid && rule_hit[r]) ? sat_inc(hit_cnt_q[r]) : hit_cnt_q[r];
        end

        // Read data is sampled from current state: pre-write and pre-increment.
        rd_val_s = BAD_RD;
        if (ar_word_s < W_TOTAL) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (ar_word_s[7:3] == r[4:0]) begin
                    case (ar_word_s[2:0])
`ifdef P2P_CFG_SHADOW_COMMIT_EN
                        3'd6:    rd_val_s = {31'd0, sh_en_q[r]};
                        3'd7:    rd_val_s = 32'(hit_cnt_q[r]);
                        default: rd_val_s = sh_cfg_q[r][3'd5 - ar_word_s[2:0]];
`else
                        3'd6:    rd_val_s = {31'd0, en_q[r]};
                        3'd7:    rd_val_s = 32'(hit_cnt_q[r]);
                        default: rd_val_s = cfg_q[r][3'd5 - ar_word_s[2:0]];
`endif
                    endcase
                end else begin
                    rd_val_s = rd_val_s;
                end
            end
        end else begin
            case (ar_word_s)
                W_TOTAL:  rd_val_s = 32'(total_cnt_q);
                W_DROP:   rd_val_s = 32'(drop_cnt_q);
                W_COMMIT: rd_val_s = 32'd0;
                W_CLEAR:  rd_val_s = 32'd0;
                default:  rd_val_s = BAD_RD;
            endcase
        end

        if (wr_fire_s && (aw_word_s < W_TOTAL)) begin
            for (int r = 0; r < NUM_RULES; r++) begin
                if (aw_word_s[7:3] == r[4:0]) begin
                    case (aw_word_s[2:0])
`ifdef P2P_CFG_SHADOW_COMMIT_EN
                        3'd6:    sh_en_d[r] = s_axil.wdata[0];
                        3'd7:    begin end
                        default: sh_cfg_d[r][3'd5 - aw_word_s[2:0]] = s_axil.wdata;
`else
                        3'd6:    en_d[r] = s_axil.wdata[0];
                        3'd7:    begin end
                        default: cfg_d[r][3'd5 - aw_word_s[2:0]] = s_axil.wdata;
`endif
                    endcase
                end else begin
                    en_d = en_d;
                end
            end
        end else if (wr_fire_s && (aw_word_s == W_CLEAR) && s_axil.wdata[0]) begin
            // Clear overrides any increment landing in the same cycle.
            hit_cnt_d   = '0;
            total_cnt_d = '0;
            drop_cnt_d  = '0;
        end else if (wr_fire_s && (aw_word_s == W_COMMIT) && s_axil.wdata[0]) begin
`ifdef P2P_CFG_SHADOW_COMMIT_EN
            cfg_d = sh_cfg_q;
            en_d  = sh_en_q;
`else
            cfg_d = cfg_q;
`endif
        end else begin
            cfg_d = cfg_d;
        end

        bvalid_d = wr_fire_s ? 1'b1 : (bvalid_q & ~s_axil.bready ? 1'b1 : 1'b0);
        rvalid_d = rd_fire_s ? 1'b1 : (rvalid_q & ~s_axil.rready ? 1'b1 : 1'b0);
        rdata_d  = rd_fire_s ? rd_val_s : rdata_q;
    end

    // State registers with synchronous reset; reset also abandons open responses.
    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            cfg_q       <= '0;
            en_q        <= '0;
`ifdef P2P_CFG_SHADOW_COMMIT_EN
            sh_cfg_q    <= '0;
            sh_en_q     <= '0;
`endif
            hit_cnt_q   <= '0;
            total_cnt_q <= '0;
            drop_cnt_q  <= '0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            cfg_q       <= cfg_d;
            en_q        <= en_d;
`ifdef P2P_CFG_SHADOW_COMMIT_EN
            sh_cfg_q    <= sh_cfg_d;
            sh_en_q     <= sh_en_d;
`endif
            hit_cnt_q   <= hit_cnt_d;
            total_cnt_q <= total_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end
endmodule
